// File: rtl/m_stage_feeder_pkg.sv
// Shared constants and state encoding for the SHA-256 message-schedule feeder.
package m_stage_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  localparam int WIN_DEPTH = 16;
  localparam int PTR_W     = 4;
  localparam int N_TAPS    = 4;
  localparam int ROUNDS    = 64;
  localparam int T_W       = 7;
  localparam int IDX_W     = 6;

  // Offsets from p = t mod 16 for W[t-15], W[t-7], W[t-2]; W[t-16] sits at p itself.
  localparam logic [PTR_W-1:0] TAP15 = 4'd1;
  localparam logic [PTR_W-1:0] TAP7  = 4'd9;
  localparam logic [PTR_W-1:0] TAP2  = 4'd14;
  localparam logic [PTR_W-1:0] TAP_OFF [N_TAPS] = '{4'd0, TAP15, TAP7, TAP2};

endpackage

// File: rtl/sha_w_window.sv
// 16-word circular W window: one write port at ptr_i, four combinational taps
// at ptr_i + {0, 1, 9, 14} (mod 16), cleared on reset.
module sha_w_window
  import m_stage_feeder_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  ptr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] tap_o [N_TAPS]
);

  logic [DATA_W-1:0] win_q [WIN_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else if (we_i) begin
      win_q[ptr_i] <= wdata_i;
    end
  end

  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
    logic [PTR_W-1:0] raddr;
    assign raddr     = ptr_i + TAP_OFF[gi];
    assign tap_o[gi] = win_q[raddr];
  end

endmodule

// File: rtl/m_stage_feeder.sv
// Loads a 16-word message block, feeds the external M stage from the sliding
// W window and streams W[0..63] to the compression stage over valid/ready.
module m_stage_feeder
  import m_stage_feeder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int M_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [DATA_W-1:0] msg_data,
  output logic [DATA_W-1:0] m_in0,
  output logic [DATA_W-1:0] m_in1,
  output logic [DATA_W-1:0] m_in2,
  output logic [DATA_W-1:0] m_in3,
  input  logic [DATA_W-1:0] m_out0,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_idx
);

  localparam int               CNT_W       = (M_LAT > 1) ? $clog2(M_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(M_LAT - 1);
  localparam logic [T_W-1:0]   T_LOAD_LAST = T_W'(WIN_DEPTH - 1);
  localparam logic [T_W-1:0]   T_LAST      = T_W'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [PTR_W-1:0]  p_q, p_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_valid_q, w_valid_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;

  logic              out_free;
  logic              load_acc;
  logic              emit_go;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] tap [N_TAPS];

  assign out_free = !w_valid_q || w_ready;
  assign load_acc = (state_q == ST_LOAD) && msg_valid && out_free;
  assign emit_go  = (state_q == ST_EMIT) && out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_idx_q   <= w_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_LOAD;
          t_d     = '0;
          p_d     = '0;
        end
      end
      ST_LOAD: begin
        if (load_acc) begin
          t_d = t_q + 7'd1;
          p_d = p_q + 4'd1;
          if (t_q == T_LOAD_LAST) begin
            state_d = ST_CALC;
            cnt_d   = '0;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Operands stay put while the consumer stalls, so m_out0 remains valid.
        if (emit_go) begin
          if (t_q == T_LAST) begin
            state_d = ST_IDLE;
          end else begin
            t_d     = t_q + 7'd1;
            p_d     = p_q + 4'd1;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_ready = (state_q == ST_LOAD) && out_free;
    done      = (state_q == ST_IDLE) && !w_valid_q;
    win_we    = load_acc || emit_go;
    win_wdata = load_acc ? msg_data : m_out0;
    w_valid_d = w_valid_q && !w_ready;
    w_data_d  = w_data_q;
    w_idx_d   = w_idx_q;
    if (win_we) begin
      w_valid_d = 1'b1;
      w_data_d  = win_wdata;
      w_idx_d   = t_q[IDX_W-1:0];
    end
  end

  sha_w_window #(
    .DATA_W(DATA_W)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .we_i   (win_we),
    .ptr_i  (p_q),
    .wdata_i(win_wdata),
    .tap_o  (tap)
  );

  assign m_in0   = tap[0];
  assign m_in1   = tap[1];
  assign m_in2   = tap[2];
  assign m_in3   = tap[3];
  assign w_valid = w_valid_q;
  assign w_data  = w_data_q;
  assign w_idx   = w_idx_q;

endmodule
